ecg_adc_axis_sampler: RTL and testbench

Upstream feeder for the AXI-Stream bandpass FIR in the ECG signal chain. It produces a fixed-rate sample tick (500 Hz from 50 MHz by default) and runs a start-convert / data-ready handshake with the external ADC. Each offset-binary ADC code is converted to a left-justified signed 16-bit sample, which the block presents on a single-beat AXI-Stream master port. Dropped ticks and ADC timeouts are reported as status.

---
 rtl/ecg_adc_axis_sampler.sv | 147 ++++++++++++++
 tb/tb_ecg_adc_axis_sampler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_adc_axis_sampler.sv
// ecg_adc_axis_sampler: fixed-rate ADC sampler feeding a single-beat AXI-Stream master.
// A tick divider paces start-convert pulses. Each offset-binary ADC code is turned
// into a left-justified signed 16-bit sample. Dropped ticks and ADC timeouts are
// reported as sticky status.
module ecg_adc_axis_sampler #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned FS_HZ       = 500,
  parameter int unsigned ADC_W       = 12,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             adc_convst,
  input  logic             adc_drdy,
  input  logic [ADC_W-1:0] adc_data,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [15:0]      m_axis_tdata,
  output logic [7:0]       overrun_cnt,
  output logic             timeout_err
);

  localparam int unsigned DIV = CLK_HZ / FS_HZ;
  localparam int unsigned DCW = $clog2(DIV);
  localparam int unsigned TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [DCW-1:0] div_cnt;
  logic           tick;
  logic [TCW-1:0] wait_cnt;
  logic           timeout_hit;
  logic [15:0]    conv_data;

  assign tick        = en && (div_cnt == DCW'(DIV - 1));
  assign timeout_hit = (wait_cnt == TCW'(TIMEOUT_CYC - 1));

  // Free-running sample divider; its phase depends only on en, never on the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Offset binary to two's complement (invert MSB), then left-justify to 16 bits.
  always_comb begin
    conv_data = '0;
    conv_data = 16'({~adc_data[ADC_W-1], adc_data[ADC_W-2:0]}) << (16 - ADC_W);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and stream-valid decode; drdy takes priority over timeout.
  always_comb begin
    state_next    = state;
    m_axis_tvalid = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_next = CONV;
        end
      end
      CONV: begin
        if (adc_drdy) begin
          state_next = SEND;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Start-convert pulse lines up with the first CONV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_convst <= 1'b0;
    end else begin
      adc_convst <= (state == IDLE) && tick;
    end
  end

  // CONV wait counter; held at zero outside CONV so it is clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state != CONV) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sample register; written only when the ADC answers during CONV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata <= '0;
    end else if ((state == CONV) && adc_drdy) begin
      m_axis_tdata <= conv_data;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if ((state == CONV) && !adc_drdy && timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end

  // Saturating count of ticks that arrive while a sample is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
    end else if (tick && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecg_adc_axis_sampler.sv
// Bench for ecg_adc_axis_sampler: ADC model, scoreboard and stream monitor.
module tb_ecg_adc_axis_sampler;

  localparam int unsigned ADC_W = 12;
  localparam int DIV = 10;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             adc_convst;
  logic             adc_drdy;
  logic [ADC_W-1:0] adc_data;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [15:0]      m_axis_tdata;
  logic [7:0]       overrun_cnt;
  logic             timeout_err;

  typedef struct {
    logic [ADC_W-1:0] code;
    logic [15:0]      exp;
  } vec_t;

  vec_t        code_q[$];
  logic [15:0] sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_convst = -100;
  int hs_cnt = 0;
  int conv_cnt = 0;
  bit adc_on = 1'b1;

  ecg_adc_axis_sampler #(
    .CLK_HZ(1000),
    .FS_HZ(100),
    .ADC_W(ADC_W),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .adc_convst(adc_convst),
    .adc_drdy(adc_drdy),
    .adc_data(adc_data),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: signed value = code - 2^(W-1), scaled to full 16-bit range.
  function automatic logic [15:0] ref_sample(input logic [ADC_W-1:0] code);
    int s;
    s = int'(code) - (2 ** (ADC_W - 1));
    s = s * (2 ** (16 - ADC_W));
    return 16'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_convst(output int c);
    c = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (adc_convst) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("convst_wait_timeout", 0, 1);
  endtask

  task automatic wait_tvalid_rise();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("tvalid_wait_timeout", 0, 1);
  endtask

  task automatic wait_hs(input int n);
    int target;
    target = hs_cnt + n;
    for (int k = 0; k < 100 * n; k++) begin
      if (hs_cnt >= target) break;
      @(posedge clk);
      #1;
    end
    if (hs_cnt < target) check("handshake_wait_timeout", hs_cnt, target);
  endtask

  // ADC model: answers each convst LAT cycles later, otherwise sprinkles stray drdy.
  initial begin
    int   cd;
    bit   prev;
    bit   drove;
    vec_t v;
    cd = 0;
    prev = 1'b0;
    adc_drdy = 1'b0;
    adc_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cd = 0;
        prev = 1'b0;
        adc_drdy = 1'b0;
        continue;
      end
      adc_drdy = 1'b0;
      adc_data = ADC_W'($urandom);
      drove = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (code_q.size() > 0) begin
            v = code_q.pop_front();
          end else begin
            v.code = ADC_W'($urandom);
            v.exp  = ref_sample(v.code);
          end
          adc_data = v.code;
          adc_drdy = 1'b1;
          drove = 1'b1;
          sb.push_back(v.exp);
        end
      end
      if (adc_convst) begin
        check("convst_single_cycle", prev, 0);
        last_convst = cyc;
        conv_cnt++;
        if (adc_on) cd = LAT;
      end else if (!drove && cd == 0 && adc_on && $urandom_range(0, 7) == 0) begin
        adc_drdy = 1'b1;
      end
      prev = adc_convst;
    end
  end

  // Stream monitor: pops the scoreboard on each accepted beat.
  initial begin
    bit          hold;
    bit          prev_v;
    bit          prev_hs;
    logic [15:0] held;
    hold = 1'b0;
    prev_v = 1'b0;
    prev_hs = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
        prev_v = 1'b0;
        prev_hs = 1'b0;
        continue;
      end
      if (m_axis_tvalid && !prev_v) check("tvalid_latency", cyc - last_convst, LAT + 1);
      if (prev_hs) check("tvalid_low_after_accept", m_axis_tvalid, 0);
      if (hold) begin
        check("tvalid_held", m_axis_tvalid, 1);
        check("tdata_stable", m_axis_tdata, held);
      end
      if (m_axis_tvalid) check("tvalid_expected", sb.size() != 0, 1);
      if (m_axis_tvalid && m_axis_tready && sb.size() != 0) begin
        check("tdata", m_axis_tdata, sb.pop_front());
        hs_cnt++;
      end
      hold    = m_axis_tvalid && !m_axis_tready;
      held    = m_axis_tdata;
      prev_v  = m_axis_tvalid;
      prev_hs = m_axis_tvalid && m_axis_tready;
    end
  end

  initial begin
    int c;
    int c2;
    int r;
    int n0;
    int h0;
    int ct[$];
    bit seen;
    vec_t v;

    rst_n = 1'b0;
    en = 1'b0;
    m_axis_tready = 1'b1;
    #2;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_convst", adc_convst, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_timeout", timeout_err, 0);

    v.code = 12'hFFF; v.exp = 16'h7FF0; code_q.push_back(v);
    v.code = 12'h800; v.exp = 16'h0000; code_q.push_back(v);
    v.code = 12'h000; v.exp = 16'h8000; code_q.push_back(v);
    v.code = 12'h7FF; v.exp = 16'hFFF0; code_q.push_back(v);

    tick_cycles(2);
    rst_n = 1'b1;
    en = 1'b1;
    r = cyc;
    wait_convst(c);
    check("first_convst", c, r + DIV);
    wait_hs(4);

    // Free run: convst period and no overruns.
    for (int i = 0; i < 20; i++) begin
      wait_convst(c);
      ct.push_back(c);
    end
    for (int i = 1; i < 20; i++) check("convst_period", ct[i] - ct[i-1], DIV);
    check("overrun_free_run", overrun_cnt, 0);

    // Backpressure: two ticks land while the beat is stalled.
    wait_tvalid_rise();
    m_axis_tready = 1'b0;
    tick_cycles(20);
    check("overrun_bp", overrun_cnt, 2);
    m_axis_tready = 1'b1;
    wait_hs(3);
    check("overrun_after_bp", overrun_cnt, 2);

    // Long stall saturates the overrun counter.
    wait_tvalid_rise();
    m_axis_tready = 1'b0;
    tick_cycles(3000);
    check("overrun_saturate", overrun_cnt, 255);
    m_axis_tready = 1'b1;
    wait_hs(1);
    check("overrun_sat_hold", overrun_cnt, 255);

    // Silent ADC: timeout after 8 cycles, next tick still converts.
    adc_on = 1'b0;
    wait_convst(c);
    tick_cycles(7);
    check("timeout_not_yet", timeout_err, 0);
    tick_cycles(1);
    check("timeout_set", timeout_err, 1);
    wait_convst(c2);
    check("convst_after_timeout", c2, c + DIV);
    tick_cycles(9);
    adc_on = 1'b1;
    wait_convst(c);
    check("convst_resume", c, c2 + DIV);
    wait_hs(2);
    check("timeout_sticky", timeout_err, 1);

    // Drop en during CONV: in-flight sample completes, then silence.
    wait_convst(c);
    en = 1'b0;
    h0 = hs_cnt;
    tick_cycles(1);
    n0 = conv_cnt;
    tick_cycles(39);
    check("en_off_delivered", hs_cnt, h0 + 1);
    check("en_off_no_convst", conv_cnt, n0);
    en = 1'b1;
    r = cyc;
    wait_convst(c);
    check("en_on_convst", c, r + DIV);

    // Reset while a beat is stalled.
    wait_tvalid_rise();
    m_axis_tready = 1'b0;
    tick_cycles(2);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tdata", m_axis_tdata, 0);
    check("midrst_convst", adc_convst, 0);
    check("midrst_overrun", overrun_cnt, 0);
    check("midrst_timeout", timeout_err, 0);
    tick_cycles(2);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    r = cyc;
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick_cycles(1);
      if (m_axis_tvalid || adc_convst) seen = 1'b1;
    end
    check("no_stale_beat", seen, 0);
    wait_convst(c);
    check("convst_after_reset", c, r + DIV);
    wait_hs(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
